// File: rtl/udc_hb_ssd_pkg.sv
// Shared definitions for the up/down counter seven-segment display block.
// Holds the count-mode encodings, the active-low glyph table for hex digits
// 0..F in {g,f,e,d,c,b,a} order, the blanking pattern and a helper that
// returns the highest legal digit value for a given mode.
package udc_hb_ssd_pkg;

  typedef enum logic {
    MODE_HEX = 1'b0,
    MODE_BCD = 1'b1
  } mode_t;

  // Active-low segment glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  // All segments off
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] HEX_DIGIT_MAX = 4'hF;
  localparam logic [3:0] BCD_DIGIT_MAX = 4'h9;

  // Highest value a single digit may hold in the given mode
  function automatic logic [3:0] digit_max(input mode_t mode);
    logic [3:0] result;
    case (mode)
      MODE_HEX: result = HEX_DIGIT_MAX;
      MODE_BCD: result = BCD_DIGIT_MAX;
      default:  result = HEX_DIGIT_MAX;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/udc_hb_ssd_mux_dec.sv
// Hex-to-seven-segment decoder.
// Ports:
//   nibble - 4-bit value 0..F to display
//   seg    - active-low segments {g,f,e,d,c,b,a}
module hex_ssd_dec
  import udc_hb_ssd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Glyph lookup for one nibble
  always_comb begin
    case (nibble)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      4'hF:    seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/udc_hb_ssd_mux.sv
// Multi-digit up/down counter (hex or BCD) driving a multiplexed
// seven-segment display with optional leading-zero blanking.
// Ports:
//   udc_hb_ssd_clk        - clock, all state on rising edge
//   udc_hb_ssd_rst        - asynchronous active-low reset
//   udc_hb_ssd_en         - count enable
//   udc_hb_ssd_dir        - count direction, 1 up / 0 down
//   udc_hb_ssd_sel        - mode select, 0 hex / 1 BCD
//   udc_hb_ssd_blank_en   - leading-zero blanking enable
//   udc_hb_ssd_status_led - {sel, dir, en}, combinational mirror
//   udc_hb_ssd_count      - packed count, digit 0 in bits [3:0]
//   udc_hb_ssd_wrap       - one-clock pulse on count wrap-around
//   udc_hb_ssd_cc         - registered active-low cathodes {g,f,e,d,c,b,a}
//   udc_hb_ssd_an         - registered active-low one-hot anodes
module udc_hb_ssd_mux
  import udc_hb_ssd_pkg::*;
#(
  parameter int DIGITS             = 4,
  parameter int clk_counter_value  = 0,
  parameter int scan_counter_value = 0
) (
  input  logic                  udc_hb_ssd_clk,
  input  logic                  udc_hb_ssd_rst,
  input  logic                  udc_hb_ssd_en,
  input  logic                  udc_hb_ssd_dir,
  input  logic                  udc_hb_ssd_sel,
  input  logic                  udc_hb_ssd_blank_en,
  output logic [2:0]            udc_hb_ssd_status_led,
  output logic [4*DIGITS-1:0]   udc_hb_ssd_count,
  output logic                  udc_hb_ssd_wrap,
  output logic [6:0]            udc_hb_ssd_cc,
  output logic [DIGITS-1:0]     udc_hb_ssd_an
);

  // Counter widths; a divider value of 0 still needs one bit of storage
  localparam int TW  = (clk_counter_value > 0) ? $clog2(clk_counter_value + 1) : 1;
  localparam int SCW = (scan_counter_value > 0) ? $clog2(scan_counter_value + 1) : 1;
  localparam int SW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [TW-1:0]  TICK_LAST = TW'(clk_counter_value);
  localparam logic [SCW-1:0] SCAN_LAST = SCW'(scan_counter_value);
  localparam logic [SW-1:0]  IDX_LAST  = SW'(DIGITS - 1);

  logic [TW-1:0]          tick_cnt;
  logic                   tick;
  logic [4*DIGITS-1:0]    count;
  mode_t                  mode;
  logic                   wrap;
  logic [SCW-1:0]         scan_cnt;
  logic                   scan_tick;
  logic [SW-1:0]          scan_idx;
  logic [DIGITS-1:0]      an;
  logic [6:0]             cc;

  logic [4*DIGITS-1:0]    count_step;
  logic                   step_carry;
  logic [3:0]             step_max;
  logic [3:0]             step_dig;
  logic [DIGITS-1:0]      blank_vec;
  logic                   upper_zero;
  logic [3:0]             scan_nib;
  logic                   scan_blank;
  logic [DIGITS-1:0]      an_next;
  logic [6:0]             seg_glyph;
  mode_t                  sel_mode;

  assign udc_hb_ssd_status_led = {udc_hb_ssd_sel, udc_hb_ssd_dir, udc_hb_ssd_en};
  assign udc_hb_ssd_count      = count;
  assign udc_hb_ssd_wrap       = wrap;
  assign udc_hb_ssd_cc         = cc;
  assign udc_hb_ssd_an         = an;

  assign tick      = (tick_cnt == TICK_LAST);
  assign scan_tick = (scan_cnt == SCAN_LAST);
  assign sel_mode  = mode_t'(udc_hb_ssd_sel);

  // Tick divider: counts 0..clk_counter_value, tick on the terminal value
  always_ff @(posedge udc_hb_ssd_clk or negedge udc_hb_ssd_rst) begin
    if (!udc_hb_ssd_rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // One-step increment/decrement with carry/borrow rippling across every
  // digit in the same clock; the carry out of the top digit is the wrap.
  always_comb begin
    count_step = count;
    step_carry = 1'b1;
    step_max   = digit_max(mode);
    step_dig   = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      step_dig = count[4*i +: 4];
      if (step_carry) begin
        if (udc_hb_ssd_dir) begin
          if (step_dig >= step_max) begin
            count_step[4*i +: 4] = 4'd0;
            step_carry           = 1'b1;
          end else begin
            count_step[4*i +: 4] = step_dig + 4'd1;
            step_carry           = 1'b0;
          end
        end else begin
          if (step_dig == 4'd0) begin
            count_step[4*i +: 4] = step_max;
            step_carry           = 1'b1;
          end else begin
            count_step[4*i +: 4] = step_dig - 4'd1;
            step_carry           = 1'b0;
          end
        end
      end else begin
        count_step[4*i +: 4] = step_dig;
      end
    end
  end

  // Count, mode copy and wrap pulse; a mode change clears the count and
  // wins over a coincident tick so a half-converted value is never seen.
  always_ff @(posedge udc_hb_ssd_clk or negedge udc_hb_ssd_rst) begin
    if (!udc_hb_ssd_rst) begin
      count <= '0;
      mode  <= MODE_HEX;
      wrap  <= 1'b0;
    end else if (mode != sel_mode) begin
      count <= '0;
      mode  <= sel_mode;
      wrap  <= 1'b0;
    end else if (tick && udc_hb_ssd_en) begin
      count <= count_step;
      mode  <= mode;
      wrap  <= step_carry;
    end else begin
      count <= count;
      mode  <= mode;
      wrap  <= 1'b0;
    end
  end

  // Scan divider and digit index, free-running regardless of count enable
  always_ff @(posedge udc_hb_ssd_clk or negedge udc_hb_ssd_rst) begin
    if (!udc_hb_ssd_rst) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_tick) begin
      scan_cnt <= '0;
      if (scan_idx == IDX_LAST) begin
        scan_idx <= '0;
      end else begin
        scan_idx <= scan_idx + SW'(1);
      end
    end else begin
      scan_cnt <= scan_cnt + SCW'(1);
      scan_idx <= scan_idx;
    end
  end

  // Leading-zero map: a digit is blanked when it and every digit above it
  // are zero; digit 0 is always shown so a zero count still reads "0".
  always_comb begin
    blank_vec  = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (count[4*i +: 4] == 4'd0);
      if (i == 0) begin
        blank_vec[i] = 1'b0;
      end else begin
        blank_vec[i] = udc_hb_ssd_blank_en && upper_zero;
      end
    end
  end

  // Scan mux: pick the nibble, blank flag and anode for the current index
  always_comb begin
    scan_nib   = 4'd0;
    scan_blank = 1'b0;
    an_next    = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (scan_idx == SW'(i)) begin
        scan_nib   = count[4*i +: 4];
        scan_blank = blank_vec[i];
        an_next[i] = 1'b0;
      end else begin
        an_next[i] = 1'b1;
      end
    end
  end

  hex_ssd_dec u_hex_ssd_dec (
    .nibble (scan_nib),
    .seg    (seg_glyph)
  );

  // Registered display drive, one clock behind the scan index
  always_ff @(posedge udc_hb_ssd_clk or negedge udc_hb_ssd_rst) begin
    if (!udc_hb_ssd_rst) begin
      an <= '1;
      cc <= SEG_BLANK;
    end else begin
      an <= an_next;
      cc <= scan_blank ? SEG_BLANK : seg_glyph;
    end
  end

endmodule

// File: doc/udc_hb_ssd_mux.md
UDC_HB_SSD_MUX -- requirements
Module: udc_hb_ssd_mux

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, the number of nibble digits and anodes (legal range 1..8).
REQ-002 The block SHALL have parameter clk_counter_value, default 0, the count tick period of clk_counter_value+1 clocks.
REQ-003 The block SHALL have parameter scan_counter_value, default 0, the digit scan period of scan_counter_value+1 clocks.
REQ-004 The block SHALL have port udc_hb_ssd_clk  input  1  as its single clock, all state on its rising edge.
REQ-005 The block SHALL have port udc_hb_ssd_rst  input  1  as its reset; it is asynchronous and active-low.
REQ-006 The block SHALL have port udc_hb_ssd_en  input  1  as the count enable.
REQ-007 The block SHALL have port udc_hb_ssd_dir  input  1  as the count direction: 1 up, 0 down.
REQ-008 The block SHALL have port udc_hb_ssd_sel  input  1  as the mode select: 0 hex, 1 BCD.
REQ-009 The block SHALL have port udc_hb_ssd_blank_en  input  1  to enable leading-zero blanking.
REQ-010 The block SHALL have port udc_hb_ssd_status_led  output  3  carrying {sel, dir, en}, combinationally mirrored.
REQ-011 The block SHALL have port udc_hb_ssd_count  output  4*DIGITS  as the packed count value, digit 0 in bits [3:0].
REQ-012 The block SHALL have port udc_hb_ssd_wrap  output  1  as a one-clock pulse on count wrap-around.
REQ-013 The block SHALL have port udc_hb_ssd_cc  output  7  as the active-low cathodes {g,f,e,d,c,b,a}.
REQ-014 The block SHALL have port udc_hb_ssd_an  output  DIGITS  as the active-low one-hot anodes, bit i lighting digit i.

Function
REQ-015 The tick counter SHALL count 0..clk_counter_value and assert tick on the terminal value, then wrap to 0; with value 0, tick SHALL assert every clock.
REQ-016 The count SHALL step by one digit-0 increment only on a clock where tick=1 and en=1; otherwise it SHALL hold.
REQ-017 Hex mode SHALL use per-digit range 0..F, with carry/borrow rippling across all DIGITS within the same clock.
REQ-018 BCD mode SHALL use per-digit range 0..9: up 9->0 with carry, down 0->9 with borrow.
REQ-019 Up from all-max (F..F or 9..9) SHALL give all-zero, and down from all-zero SHALL give all-max; either case SHALL pulse wrap for exactly that clock.
REQ-020 The block SHALL hold a registered mode copy; when sel differs from it, the next clock SHALL update the mode and clear the count to 0, with no wrap pulse, taking priority over a coincident tick.
REQ-021 The scan index SHALL advance 0..DIGITS-1 every scan_counter_value+1 clocks and wrap to 0, independent of en.
REQ-022 an and cc SHALL be registered, presenting the digit selected by the scan index with one clock of latency.
REQ-023 cc SHALL decode 0..F as the standard hex glyphs; for example, 5 SHALL give 7'b0010010.
REQ-024 With blank_en=1, each zero digit above the most significant non-zero digit SHALL drive cc=7'h7F; digit 0 SHALL never be blanked.

Reset
REQ-025 While rst=0, the block SHALL immediately and asynchronously force tick counter=0, count=0, mode=hex, scan index=0, wrap=0, an=all ones and cc=7'h7F.
REQ-026 Reset asserted mid-count or mid-scan SHALL discard all state; on release, the first scan clock SHALL drive digit 0.

Structure
REQ-027 A shared package udc_hb_ssd_pkg SHALL hold the mode encodings (hex=0, BCD=1), the 16-entry segment glyph constants and the blank pattern 7'h7F.
REQ-028 Hex-to-segment decoding SHALL be a single sub-module hex_ssd_dec (4-bit in, 7-bit active-low out), instantiated once after the scan mux.

Verification (DIGITS=2, both dividers 0)
REQ-029 A bench SHALL check: rst low at count 0x37 mid-scan -> count=0x00, an=2'b11 and cc=7'h7F in the same cycle, with no clock edge needed.
REQ-030 A bench SHALL check: hex mode, en=1, dir=1 from 0xFE -> 0xFF then 0x00, with wrap=1 only on the 0x00 cycle.
REQ-031 A bench SHALL check: BCD mode up from 0x98 -> 0x99 then 0x00 with a wrap pulse; down from 0x00 -> 0x99 with a wrap pulse.
REQ-032 A bench SHALL check: hex count 0x3A, then sel set to 1 -> next clock count=0x00, mode=BCD, wrap=0, then counting 0x01, 0x02.
REQ-033 A bench SHALL check: count 0x05 with blank_en=1 -> digit 1 drives an=2'b01 with cc=7'h7F, and digit 0 drives an=2'b10 with cc=7'b0010010.
REQ-034 A bench SHALL check: en=0 for 10 clocks -> count constant and wrap=0, while an keeps alternating every clock.
